radar_core_pio_in: RTL

//  Avalon-MM slave input PIO. Lets the NIOS II read WIDTH external status bits (radar echo/ready flags) and take interrupts on them.

---
 rtl/radar_core_pio_in.sv | 136 +++++++++++++
 1 files changed

// File: rtl/radar_core_pio_in.sv
// radar_core_pio_in: Avalon-MM input PIO for the NIOS II.
// Synchronises in_port, captures selected edges into a W1C edgecapture register and raises a
// level irq through irq_mask. Register map: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE.
// Optional per-bit debounce is enabled by defining RADAR_PIO_IN_DEBOUNCE_EN.
// Assumes WIDTH < 32 so readdata always carries at least one zero-filled upper bit.
module radar_core_pio_in #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

`ifdef RADAR_PIO_IN_DEBOUNCE_EN
    localparam int unsigned Arm  = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
    localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`else
    localparam int unsigned Arm  = SYNC_STAGES + 1;
`endif
    localparam int unsigned CntW = $clog2(Arm + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [CntW-1:0]  arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:WIDTH];
    assign wr_en        = chipselect & ~write_n;
    assign s            = sync_q[SYNC_STAGES-1];

    // Synchroniser chain on the asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef RADAR_PIO_IN_DEBOUNCE_EN
    logic [DebW-1:0]  deb_cnt_q [WIDTH];
    logic [WIDTH-1:0] data_in_q;

    // Per-bit debounce: data_in follows s only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_in_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) deb_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (s[i] == data_in_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebW'(DEBOUNCE_CYCLES - 1)) begin
                    data_in_q[i] <= s[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign data_in = data_in_q;
`else
    assign data_in = s;
`endif

    // Edge selection; EDGE_TYPE is static so only one term survives synthesis.
    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = data_in & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~data_in & prev_q;
        end else begin
            edge_det = data_in ^ prev_q;
        end
    end

    assign armed = (arm_cnt_q == CntW'(Arm));

    // Next-state for arming counter, mask, edgecapture (set beats W1C) and read mux.
    always_comb begin
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
        irq_mask_d = irq_mask_q;
        edgecap_d  = edgecap_q;
        if (wr_en && address == 2'd2) irq_mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd3) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        edgecap_d = edgecap_d | (edge_det & {WIDTH{armed}});
        unique case (address)
            2'd0:    readdata_d = 32'(data_in);
            2'd2:    readdata_d = 32'(irq_mask_q);
            2'd3:    readdata_d = 32'(edgecap_q);
            default: readdata_d = '0;
        endcase
    end

    // Register state; all of it returns to zero on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
            arm_cnt_q  <= '0;
        end else begin
            prev_q     <= data_in;
            edgecap_q  <= edgecap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    assign readdata = readdata_q;
    // Driven only by flops through an OR tree, so it cannot glitch on input activity.
    assign irq      = |(edgecap_q & irq_mask_q);

endmodule
